// File: rtl/lv8_pipe_pkg.sv
// Shared types and codes for the LEGv8 pipeline hazard controller.
package lv8_pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;

    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Shadow copy of one in-flight instruction's hazard-relevant fields
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             uses_rs2;
        logic             reg_write;
        logic             mem_read;
    } slot_t;

    // True when a slot produces a register value that a reader of src needs
    function automatic logic slot_writes(input slot_t s, input logic [REG_W-1:0] src);
        return s.valid && s.reg_write && (s.rd != XZR) && (s.rd == src);
    endfunction

    // Forwarding source for one ALU operand; the younger MEM result beats WB
    function automatic logic [FWD_W-1:0] fwd_sel(input slot_t mem_s, input slot_t wb_s,
                                                  input logic [REG_W-1:0] src, input logic en);
        if (!en)                          return FWD_RF;
        else if (slot_writes(mem_s, src)) return FWD_EXMEM;
        else if (slot_writes(wb_s, src))  return FWD_MEMWB;
        else                              return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_slot.sv
// One shadow pipeline stage: holds an instruction's hazard fields.
module hazard_slot
    import lv8_pipe_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  ld,
    input  logic  clr,
    input  slot_t d,
    output slot_t q
);

    // Clear takes priority so a bubble can be loaded on an advancing edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage LEGv8 pipeline.
module pipeline_hazard_ctrl
    import lv8_pipe_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 8,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_stall,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    localparam int unsigned INIT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);

    state_t            state;
    state_t            state_nxt;
    logic [INIT_W-1:0] init_cnt;
    logic              advance;
    logic              load_use;
    logic              stall_inc;
    logic              flush_inc;
    slot_t             id_slot;
    slot_t             ex_q;
    slot_t             mem_q;
    slot_t             wb_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nxt;
    end

    // Leave INIT on the edge where the hold counter reaches zero
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_cnt <= INIT_W'(1)) begin
            state_nxt = ST_RUN;
        end
    end

    // Start-up hold counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_cnt <= INIT_W'(INIT_CYCLES);
        end else if (state == ST_INIT && init_cnt != '0) begin
            init_cnt <= init_cnt - INIT_W'(1);
        end
    end

    // Load-use: EX holds a load whose destination the ID instruction reads
    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != XZR) && id_valid &&
                      ((ex_q.rd == id_rs1) || (id_uses_rs2 && (ex_q.rd == id_rs2)));

    // Sequencing outputs by priority: mem stall, taken branch, load-use, advance
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b1;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (state == ST_RUN) begin
            if (mem_stall) begin
                idex_bubble = 1'b0;
                stall_inc   = 1'b1;
            end else if (ex_branch_taken) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                flush_inc   = 1'b1;
            end else if (load_use) begin
                stall_inc   = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_bubble = 1'b0;
            end
        end
    end

    // Performance counters, free-running modulo 2^PERF_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc) stall_cnt <= stall_cnt + PERF_W'(1);
            if (flush_inc) flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end

    // Pack the decoded ID instruction into slot form
    always_comb begin
        id_slot           = '0;
        id_slot.valid     = id_valid;
        id_slot.rd        = id_rd;
        id_slot.rs1       = id_rs1;
        id_slot.rs2       = id_rs2;
        id_slot.uses_rs2  = id_uses_rs2;
        id_slot.reg_write = id_reg_write;
        id_slot.mem_read  = id_mem_read;
    end

    assign advance = (state == ST_RUN) && !mem_stall;

    hazard_slot u_ex (
        .clk   (clk),
        .reset (reset),
        .ld    (advance),
        .clr   (advance && idex_bubble),
        .d     (id_slot),
        .q     (ex_q)
    );

    hazard_slot u_mem (
        .clk   (clk),
        .reset (reset),
        .ld    (advance),
        .clr   (1'b0),
        .d     (ex_q),
        .q     (mem_q)
    );

    hazard_slot u_wb (
        .clk   (clk),
        .reset (reset),
        .ld    (advance),
        .clr   (1'b0),
        .d     (mem_q),
        .q     (wb_q)
    );

    assign fwd_a = fwd_sel(mem_q, wb_q, ex_q.rs1, 1'b1);
    assign fwd_b = fwd_sel(mem_q, wb_q, ex_q.rs2, ex_q.uses_rs2);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        ex_branch_taken;
    logic        mem_stall;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int tests;
    int fails;
    int exp_stall;
    int exp_flush;

    pipeline_hazard_ctrl #(.INIT_CYCLES(8), .PERF_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_stall       (mem_stall),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u, input logic [4:0] rd, input logic rw, input logic mr);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_uses_rs2  = u;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        repeat (3) begin
            nop();
            @(negedge clk);
        end
    endtask

    // Counts cycles with pc_write low after release; bounded
    task automatic count_init(input string name);
        int n;
        n = 0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (pc_write) break;
            n++;
            @(negedge clk);
            #1;
        end
        tests++;
        if (n !== 8) begin
            $display("FAIL %s: pc_write low for %0d cycles, expected 8", name, n);
            fails++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        nop();
        ex_branch_taken = 1'b0;
        mem_stall = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({pc_write, ifid_write, ifid_flush, idex_bubble} !== 4'b0001) begin
            $display("FAIL reset_ctrl: got %b expected 0001", {pc_write, ifid_write, ifid_flush, idex_bubble});
            fails++;
        end
        tests++;
        if ({fwd_a, fwd_b} !== 4'b0000 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            $display("FAIL reset_fwd_cnt: fwd %b stall %0d flush %0d expected 0000 0 0",
                     {fwd_a, fwd_b}, stall_cnt, flush_cnt);
            fails++;
        end
        @(negedge clk);
        reset = 1'b0;
        count_init("init_hold");
        tests++;
        if ({pc_write, ifid_write, idex_bubble} !== 3'b110) begin
            $display("FAIL run_idle: got %b expected 110", {pc_write, ifid_write, idex_bubble});
            fails++;
        end
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);   // LDUR X2,[X1]
        @(negedge clk);
        set_id(1'b1, 5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);   // ADD X3,X2,X4
        #1;
        tests++;
        if ({pc_write, ifid_write, idex_bubble} !== 3'b001) begin
            $display("FAIL lu_stall: got %b expected 001", {pc_write, ifid_write, idex_bubble});
            fails++;
        end
        exp_stall++;
        @(negedge clk);
        #1;
        tests++;
        if ({pc_write, ifid_write, idex_bubble} !== 3'b110 || stall_cnt !== 32'(exp_stall)) begin
            $display("FAIL lu_once: got %b stall %0d expected 110 stall %0d",
                     {pc_write, ifid_write, idex_bubble}, stall_cnt, exp_stall);
            fails++;
        end
        @(negedge clk);
        nop();
        #1;
        tests++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
            $display("FAIL lu_fwd: got a=%b b=%b expected a=01 b=00", fwd_a, fwd_b);
            fails++;
        end
        drain();
    endtask

    task automatic test_forwarding();
        set_id(1'b1, 5'd6, 5'd7, 1'b1, 5'd1, 1'b1, 1'b0);   // ADD X1,X6,X7
        @(negedge clk);
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);   // SUB X5,X1,X1
        #1;
        tests++;
        if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
            $display("FAIL exmem_nostall: pc_write %b bubble %b expected 1 0", pc_write, idex_bubble);
            fails++;
        end
        @(negedge clk);
        nop();
        #1;
        tests++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
            $display("FAIL exmem_fwd: got a=%b b=%b expected 10 10", fwd_a, fwd_b);
            fails++;
        end
        drain();
        set_id(1'b1, 5'd6, 5'd7, 1'b1, 5'd1, 1'b1, 1'b0);   // ADD X1,X6,X7
        @(negedge clk);
        set_id(1'b1, 5'd9, 5'd10, 1'b1, 5'd8, 1'b1, 1'b0);  // ADD X8,X9,X10
        @(negedge clk);
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);   // SUB X5,X1,X1
        @(negedge clk);
        nop();
        #1;
        tests++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
            $display("FAIL memwb_fwd: got a=%b b=%b expected 01 01", fwd_a, fwd_b);
            fails++;
        end
        drain();
        set_id(1'b1, 5'd6, 5'd7, 1'b1, 5'd1, 1'b1, 1'b0);   // ADD X1,X6,X7
        @(negedge clk);
        set_id(1'b1, 5'd2, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);   // ADD X1,X2,X3
        @(negedge clk);
        set_id(1'b1, 5'd1, 5'd1, 1'b0, 5'd5, 1'b1, 1'b0);   // reader, rs2 unused
        @(negedge clk);
        nop();
        #1;
        tests++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
            $display("FAIL mem_over_wb: got a=%b b=%b expected 10 00", fwd_a, fwd_b);
            fails++;
        end
        drain();
    endtask

    task automatic test_xzr();
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1);  // LDUR XZR
        @(negedge clk);
        set_id(1'b1, 5'd31, 5'd31, 1'b1, 5'd3, 1'b1, 1'b0); // ADD X3,XZR,XZR
        #1;
        tests++;
        if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
            $display("FAIL xzr_nostall: pc_write %b bubble %b expected 1 0", pc_write, idex_bubble);
            fails++;
        end
        @(negedge clk);
        nop();
        #1;
        tests++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            $display("FAIL xzr_fwd: got a=%b b=%b expected 00 00", fwd_a, fwd_b);
            fails++;
        end
        drain();
    endtask

    task automatic test_branch();
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);   // LDUR X2
        @(negedge clk);
        set_id(1'b1, 5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);   // dependent ADD
        ex_branch_taken = 1'b1;
        #1;
        tests++;
        if ({pc_write, ifid_flush, idex_bubble} !== 3'b111) begin
            $display("FAIL br_squash: got %b expected 111", {pc_write, ifid_flush, idex_bubble});
            fails++;
        end
        exp_flush++;
        @(negedge clk);
        ex_branch_taken = 1'b0;
        nop();
        #1;
        tests++;
        if (flush_cnt !== 32'(exp_flush) || stall_cnt !== 32'(exp_stall)) begin
            $display("FAIL br_counts: flush %0d stall %0d expected %0d %0d",
                     flush_cnt, stall_cnt, exp_flush, exp_stall);
            fails++;
        end
        tests++;
        if (pc_write !== 1'b1 || ifid_flush !== 1'b0) begin
            $display("FAIL br_after: pc_write %b flush %b expected 1 0", pc_write, ifid_flush);
            fails++;
        end
        drain();
    endtask

    task automatic test_mem_stall();
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);   // LDUR X2
        @(negedge clk);
        set_id(1'b1, 5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);   // ADD X3,X2,X4
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if ({pc_write, ifid_write, idex_bubble} !== 3'b000) begin
                $display("FAIL ms_hold%0d: got %b expected 000", i, {pc_write, ifid_write, idex_bubble});
                fails++;
            end
            exp_stall++;
            @(negedge clk);
        end
        mem_stall = 1'b0;
        #1;
        tests++;
        if ({pc_write, ifid_write, idex_bubble} !== 3'b001 || stall_cnt !== 32'(exp_stall)) begin
            $display("FAIL ms_release: got %b stall %0d expected 001 stall %0d",
                     {pc_write, ifid_write, idex_bubble}, stall_cnt, exp_stall);
            fails++;
        end
        exp_stall++;
        @(negedge clk);
        #1;
        tests++;
        if ({pc_write, idex_bubble} !== 2'b10 || stall_cnt !== 32'(exp_stall)) begin
            $display("FAIL ms_once: got %b stall %0d expected 10 stall %0d",
                     {pc_write, idex_bubble}, stall_cnt, exp_stall);
            fails++;
        end
        @(negedge clk);
        nop();
        #1;
        tests++;
        if (fwd_a !== 2'b01) begin
            $display("FAIL ms_fwd: got a=%b expected 01", fwd_a);
            fails++;
        end
        drain();
    endtask

    task automatic test_mid_reset();
        set_id(1'b1, 5'd6, 5'd7, 1'b1, 5'd1, 1'b1, 1'b0);   // ADD X1
        @(negedge clk);
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);   // SUB X5,X1,X1
        @(negedge clk);
        nop();
        #1;
        tests++;
        if (fwd_a !== 2'b10 || stall_cnt !== 32'(exp_stall)) begin
            $display("FAIL pre_reset: fwd_a %b stall %0d expected 10 %0d", fwd_a, stall_cnt, exp_stall);
            fails++;
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b} !== 8'b0001_0000 ||
            stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            $display("FAIL mid_reset: ctrl/fwd %b stall %0d flush %0d expected 00010000 0 0",
                     {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b}, stall_cnt, flush_cnt);
            fails++;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        count_init("init_restart");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_stall = 0;
        exp_flush = 0;
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        mem_stall = 1'b0;
        nop();
        test_reset();
        test_load_use();
        test_forwarding();
        test_xzr();
        test_branch();
        test_mem_stall();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
